// File: rtl/adc_resp_pkg.sv
// Shared types and constants for the ADC responder (LTC2308-style emulator).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package adc_resp_pkg;

    localparam int ADC_DATA_W      = 12;
    localparam int ADC_CONV_CYCLES = 80;
    localparam int CFG_W           = 6;

    // Config word bit positions, {SD,OS,S1,S0,UNI,SLP}
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    // Single-ended channel 0, unipolar
    localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

    // Offset-binary flip for bipolar results at the default width
    localparam logic [ADC_DATA_W-1:0] BIPOLAR_FLIP = 12'h800;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_READY,
        ST_SHIFT
    } adc_state_t;

    // Channel address; SD=0 (differential) shares the single-ended address
    function automatic logic [2:0] cfg_chan(input logic [CFG_W-1:0] cfg);
        return {cfg[CFG_OS], cfg[CFG_S1], cfg[CFG_S0]};
    endfunction

endpackage

// File: rtl/adc_responder_if.sv
// Serial ADC bus between the ADC master and the emulated device.
// Latency: n/a (wires only).
// Backpressure: none; the master owns all timing.
interface adc_responder_if;
    logic convst;
    logic sck;
    logic sdi;
    logic sdo;

    modport master (output convst, output sck, output sdi, input sdo);
    modport slave  (input convst, input sck, input sdi, output sdo);
endinterface

// File: rtl/adc_sync_edge.sv
// Multi-flop synchronizer for an async pin, with registered-edge rise/fall pulses.
// Latency: level after STAGES clk; rise/fall pulse valid in the same cycle as the new level.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module adc_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer and remember the previous level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl  = sync_q[STAGES-1];
    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

// File: rtl/adc_responder.sv
// LTC2308-style ADC device emulator; channel values come from a write port. Optional macro ADC_RESP_RAMP_EN.
// Latency: pin-to-effect SYNC_STAGES+1 clk; data ready CONV_CYCLES clk after the convst rise is seen.
// Backpressure: none; master must hold each SCK level >= SYNC_STAGES+2 clk, protocol misuse pulses proto_err.
module adc_responder
    import adc_resp_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int CONV_CYCLES = ADC_CONV_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    adc_responder_if.slave      adc,
    input  logic                ch_wr_en,
    input  logic [2:0]          ch_wr_sel,
    input  logic [DATA_W-1:0]   ch_wr_data,
    output logic [CFG_W-1:0]    last_cfg,
    output logic                frame_done,
    output logic                proto_err
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] FLIP = {1'b1, {(DATA_W-1){1'b0}}};

    logic cv_rise, cv_fall, cv_lvl;
    logic sck_rise, sck_fall, sck_lvl;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic sync_edges_unused;

    adc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_convst (
        .clk(clk), .reset(reset), .din(adc.convst),
        .lvl(cv_lvl), .rise(cv_rise), .fall(cv_fall)
    );

    adc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .din(adc.sck),
        .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    adc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(clk), .reset(reset), .din(adc.sdi),
        .lvl(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
    );

    assign sync_edges_unused = cv_lvl | cv_fall | sck_lvl | sdi_rise | sdi_fall;

    adc_state_t        state;
    logic [CNT_W-1:0]  conv_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [2:0]        rise_cnt;
    logic [CFG_W-1:0]  shadow;
    logic [DATA_W-1:0] shreg;
    logic              sdo_q;
    logic [DATA_W-1:0] chan_q [8];

    logic              sample_now;
    logic [2:0]        sample_sel;
    logic [DATA_W-1:0] sample_val;
    logic [DATA_W-1:0] result;

    // A convst rise outside CONV is the sample instant (a rise during CONV is an error)
    assign sample_now = cv_rise && (state != ST_CONV);
    assign sample_sel = cfg_chan(last_cfg);
    assign sample_val = chan_q[sample_sel];
    assign result     = last_cfg[CFG_UNI] ? sample_val : (sample_val ^ FLIP);
    assign adc.sdo    = sdo_q;

    // Protocol FSM: conversion timer, SDO shifter, SDI config capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            conv_cnt   <= '0;
            bit_cnt    <= '0;
            rise_cnt   <= '0;
            shadow     <= '0;
            shreg      <= '0;
            sdo_q      <= 1'b0;
            last_cfg   <= CFG_RESET;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sample_now) begin
                        state    <= ST_CONV;
                        conv_cnt <= '0;
                        shreg    <= result;
                    end
                end
                ST_CONV: begin
                    if (cv_rise || sck_rise || sck_fall) begin
                        proto_err <= 1'b1;
                    end
                    if (conv_cnt == CNT_W'(CONV_CYCLES - 1)) begin
                        state    <= ST_READY;
                        sdo_q    <= shreg[DATA_W-1];
                        shreg    <= {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt  <= '0;
                        rise_cnt <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                ST_READY, ST_SHIFT: begin
                    if (sample_now) begin
                        // Abort: restart conversion, any partial config is dropped
                        state    <= ST_CONV;
                        conv_cnt <= '0;
                        shreg    <= result;
                        sdo_q    <= 1'b0;
                        rise_cnt <= '0;
                    end else begin
                        if (sck_rise && (rise_cnt < 3'd6)) begin
                            shadow   <= {shadow[CFG_W-2:0], sdi_lvl};
                            rise_cnt <= rise_cnt + 1'b1;
                            if (rise_cnt == 3'd5) begin
                                last_cfg <= {shadow[CFG_W-2:0], sdi_lvl};
                            end
                        end
                        if (sck_fall) begin
                            // Zeros shift in behind the data, so SDO idles low after bit 0
                            sdo_q <= shreg[DATA_W-1];
                            shreg <= {shreg[DATA_W-2:0], 1'b0};
                            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                                state      <= ST_IDLE;
                                frame_done <= 1'b1;
                            end else begin
                                state   <= ST_SHIFT;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Channel register bank; a same-cycle write overrides the ramp increment
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
`ifdef ADC_RESP_RAMP_EN
            if (sample_now) begin
                chan_q[sample_sel] <= sample_val + 1'b1;
            end
`endif
            if (ch_wr_en) begin
                chan_q[ch_wr_sel] <= ch_wr_data;
            end
        end
    end

endmodule
